// File: rtl/pipeline_swap_ctrl_if.sv
// Bus bundle for pipeline_swap_ctrl: SPI command FIFO head, payload forwarding,
// pipeline sample inputs and mixed output/status. Controller uses the slave modport.
interface pipeline_swap_ctrl_if #(
   parameter int n_pipelines = 4,
   parameter int data_width  = 16
);
   localparam int AW = $clog2(n_pipelines);

   logic [7:0]                        cmd_byte;
   logic                              cmd_valid;
   logic                              cmd_read;
   logic [7:0]                        fwd_byte;
   logic [n_pipelines-1:0]            fwd_ready;
   logic [n_pipelines-1:0]            fwd_read;
   logic [n_pipelines-1:0]            pipe_ready;
   logic [n_pipelines*data_width-1:0] pipe_samples;
   logic                              sample_valid;
   logic [data_width-1:0]             out_sample;
   logic                              out_valid;
   logic [AW-1:0]                     active;
   logic                              swapping;
   logic                              error;

   modport master (
      output cmd_byte, cmd_valid, fwd_read, pipe_ready, pipe_samples, sample_valid,
      input  cmd_read, fwd_byte, fwd_ready, out_sample, out_valid, active, swapping, error
   );

   modport slave (
      input  cmd_byte, cmd_valid, fwd_read, pipe_ready, pipe_samples, sample_valid,
      output cmd_read, fwd_byte, fwd_ready, out_sample, out_valid, active, swapping, error
   );
endinterface

// File: rtl/pipeline_swap_ctrl.sv
// Command-driven DSP pipeline loader and live-pipeline swapper with output mixing.
// Define SWAP_XFADE_EN for a linear crossfade; otherwise swaps are a hard cut.
module pipeline_swap_ctrl #(
   parameter int n_pipelines = 4,
   parameter int data_width  = 16,
   parameter int xfade_log2  = 6
) (
   input logic                clk,
   input logic                reset,
   pipeline_swap_ctrl_if.slave bus
);
   localparam int AW  = $clog2(n_pipelines);
   localparam int DW  = data_width;
   localparam int DW1 = data_width + 1;
   localparam logic [n_pipelines-1:0] ONE = {{(n_pipelines-1){1'b0}}, 1'b1};

   if (n_pipelines < 2 || n_pipelines > 16 || data_width < 2 || xfade_log2 < 1) begin : g_param_check
      $error("pipeline_swap_ctrl: unsupported parameter set");
   end

`ifdef SWAP_XFADE_EN
   typedef enum logic [2:0] {IDLE, LEN, FWD, SWAP_WAIT, XFADE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LEN, FWD, SWAP_WAIT} state_t;
`endif

   state_t                 r_state;
   logic [AW-1:0]          r_active;
   logic [AW-1:0]          r_target;
   logic                   r_discard;
   logic [7:0]             r_count;
   logic                   r_cmd_read;
   logic [7:0]             r_fwd_byte;
   logic [n_pipelines-1:0] r_fwd_ready;
   logic [DW-1:0]          r_out_sample;
   logic                   r_out_valid;
   logic                   r_error;
   logic                   r_act_rdy_q;

   logic                   w_pop;
   logic [4:0]             w_k;
   logic                   w_k_oob;
   logic                   w_k_is_act;
   logic [AW-1:0]          w_k_idx;
   logic signed [DW-1:0]   w_old;
   logic signed [DW-1:0]   w_new;
   logic                   w_act_rdy;
   logic                   w_tgt_rdy;

   // The pop pulse is still high while the FIFO head is stale, so it blocks a re-read.
   assign w_pop      = bus.cmd_valid && !r_cmd_read;
   assign w_k        = {1'b0, bus.cmd_byte[3:0]};
   assign w_k_oob    = (w_k >= 5'(n_pipelines));
   assign w_k_is_act = (w_k == 5'(r_active));
   assign w_k_idx    = bus.cmd_byte[AW-1:0];
   assign w_old      = bus.pipe_samples[r_active*DW +: DW];
   assign w_new      = bus.pipe_samples[r_target*DW +: DW];
   assign w_act_rdy  = bus.pipe_ready[r_active];
   assign w_tgt_rdy  = bus.pipe_ready[r_target];

`ifdef SWAP_XFADE_EN
   localparam int PW = data_width + 1 + xfade_log2;
   logic [xfade_log2-1:0]  r_c;
   logic signed [DW1-1:0]  w_diff;
   logic signed [PW-1:0]   w_prod;
   logic signed [DW-1:0]   w_mix;

   assign w_diff = DW1'(w_new) - DW1'(w_old);
   assign w_prod = PW'(w_diff) * PW'($signed({1'b0, r_c}));
   assign w_mix  = DW'(PW'(w_old) + (w_prod >>> xfade_log2));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_active     <= '0;
         r_target     <= '0;
         r_discard    <= 1'b0;
         r_count      <= '0;
         r_cmd_read   <= 1'b0;
         r_fwd_byte   <= '0;
         r_fwd_ready  <= '0;
         r_out_sample <= '0;
         r_out_valid  <= 1'b0;
         r_error      <= 1'b0;
         r_act_rdy_q  <= 1'b0;
`ifdef SWAP_XFADE_EN
         r_c          <= '0;
`endif
      end else begin
         r_cmd_read  <= 1'b0;
         r_act_rdy_q <= w_act_rdy;
         if (r_act_rdy_q && !w_act_rdy) r_error <= 1'b1;
         r_out_valid <= bus.sample_valid;
         if (bus.sample_valid) r_out_sample <= w_old;

         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_cmd_read <= 1'b1;
                  if (bus.cmd_byte[7:4] == 4'h8) begin
                     r_target  <= w_k_idx;
                     r_discard <= w_k_oob || w_k_is_act;
                     if (w_k_oob || w_k_is_act) r_error <= 1'b1;
                     r_state   <= LEN;
                  end else if (bus.cmd_byte[7:4] == 4'h9) begin
                     if (w_k_oob) begin
                        r_error <= 1'b1;
                     end else if (!w_k_is_act) begin
                        r_target <= w_k_idx;
                        r_state  <= SWAP_WAIT;
                     end
                  end else begin
                     r_error <= 1'b1;
                  end
               end
            end
            LEN: begin
               if (w_pop) begin
                  r_cmd_read <= 1'b1;
                  if (bus.cmd_byte == 8'h00) begin
                     r_error <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_count <= bus.cmd_byte;
                     r_state <= FWD;
                  end
               end
            end
            FWD: begin
               if (r_fwd_ready != '0) begin
                  if (bus.fwd_read[r_target]) begin
                     r_fwd_ready <= '0;
                     r_count     <= r_count - 8'd1;
                     if (r_count == 8'd1) r_state <= IDLE;
                  end
               end else if (w_pop) begin
                  r_cmd_read <= 1'b1;
                  if (r_discard) begin
                     r_count <= r_count - 8'd1;
                     if (r_count == 8'd1) r_state <= IDLE;
                  end else begin
                     r_fwd_byte  <= bus.cmd_byte;
                     r_fwd_ready <= ONE << r_target;
                  end
               end
            end
`ifdef SWAP_XFADE_EN
            SWAP_WAIT: begin
               if (w_tgt_rdy) begin
                  r_c     <= '0;
                  r_state <= XFADE;
               end
            end
            XFADE: begin
               if (bus.sample_valid) begin
                  r_out_sample <= w_mix;
                  if (&r_c) begin
                     r_active <= r_target;
                     r_state  <= IDLE;
                  end else begin
                     r_c <= r_c + 1'b1;
                  end
               end
            end
`else
            SWAP_WAIT: begin
               if (w_tgt_rdy && bus.sample_valid) begin
                  r_out_sample <= w_new;
                  r_active     <= r_target;
                  r_state      <= IDLE;
               end
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_read   = r_cmd_read;
   assign bus.fwd_byte   = r_fwd_byte;
   assign bus.fwd_ready  = r_fwd_ready;
   assign bus.out_sample = r_out_sample;
   assign bus.out_valid  = r_out_valid;
   assign bus.active     = r_active;
   assign bus.error      = r_error;
`ifdef SWAP_XFADE_EN
   assign bus.swapping   = (r_state == SWAP_WAIT) || (r_state == XFADE);
`else
   assign bus.swapping   = (r_state == SWAP_WAIT);
`endif
endmodule

// File: doc/pipeline_swap_ctrl.md
PIPELINE_SWAP_CTRL -- requirements
Module: pipeline_swap_ctrl

Interface
REQ-001 Parameter n_pipelines, default 4: number of DSP pipelines managed (2..16).
REQ-002 Parameter data_width, default 16: signed sample width.
REQ-003 Parameter xfade_log2, default 6: crossfade length is 2^xfade_log2 samples.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_byte  in  8  head byte of SPI command FIFO.
REQ-007 cmd_valid  in  1  cmd_byte holds a valid byte.
REQ-008 cmd_read  out  1  one-cycle pop pulse to FIFO.
REQ-009 fwd_byte  out  8  payload byte offered to target pipeline.
REQ-010 fwd_ready  out  n_pipelines  one-hot, fwd_byte valid for pipeline k.
REQ-011 fwd_read  in  n_pipelines  pipeline k consumed fwd_byte.
REQ-012 pipe_ready  in  n_pipelines  pipeline k configured and running.
REQ-013 pipe_samples  in  n_pipelines*data_width  output samples, pipeline k at bits [k*data_width +: data_width].
REQ-014 sample_valid  in  1  one-cycle strobe, all pipe_samples valid.
REQ-015 out_sample  out  data_width  mixed output sample, signed.
REQ-016 out_valid  out  1  out_sample updated this cycle.
REQ-017 active  out  clog2(n_pipelines)  index of live pipeline.
REQ-018 swapping  out  1  high in SWAP_WAIT or XFADE.
REQ-019 error  out  1  sticky protocol error flag.

Function
REQ-020 Commands: 0x8k = load pipeline k, next byte L (1..255), then L payload bytes; 0x9k = swap to pipeline k; other bytes discarded with error set.
REQ-021 States IDLE, LEN, FWD, SWAP_WAIT, XFADE; only IDLE/LEN/FWD pop cmd bytes.
REQ-022 cmd_read pulses exactly once per byte consumed, in the cycle after cmd_valid is seen in a consuming state; never two consecutive cycles.
REQ-023 FWD: latch byte to fwd_byte, assert fwd_ready[k] until fwd_read[k]; then pop next byte; after L bytes return to IDLE.
REQ-024 fwd_read on non-selected bit ignored; L=0 treated as error, return to IDLE.
REQ-025 Load or swap with k >= n_pipelines, or load of k == active: set error, discard command (and for load, its L payload bytes, consumed without forwarding).
REQ-026 Swap to k == active: no-op, no error.
REQ-027 SWAP_WAIT: wait until pipe_ready[k], then XFADE with counter c=0.
REQ-028 out_sample/out_valid registered: out_valid one cycle after each sample_valid, never otherwise.
REQ-029 Outside XFADE out_sample = pipe_samples[active].
REQ-030 In XFADE out = old + (((new-old) * c) >>> xfade_log2), diff width data_width+1, product width data_width+1+xfade_log2, arithmetic shift; c increments per sample_valid.
REQ-031 After sample with c = 2^xfade_log2-1, active <= k, return to IDLE; next sample is pure new.
REQ-032 cmd bytes arriving during SWAP_WAIT/XFADE remain in FIFO (not popped).
REQ-033 pipe_ready[active] deasserting sets error; output unaffected.

Reset
REQ-034 Reset: state IDLE, active=0, out_sample=0, out_valid=0, cmd_read=0, fwd_ready=0, fwd_byte=0, swapping=0, error=0, counters 0.
REQ-035 Reset mid-FWD/XFADE abandons the operation; remaining payload stays in FIFO.

Configuration
REQ-036 SWAP_XFADE_EN defined: crossfade per REQ-030/031.
REQ-037 SWAP_XFADE_EN undefined: no XFADE state or multiplier; on pipe_ready[k] active switches to k at next sample_valid (hard cut), parameter xfade_log2 unused.

Verification
REQ-038 Feed 0x81,0x03,0xA1,0xA2,0xA3; pipeline1 acks each after 2 cycles -> fwd_ready=0b0010 three times, bytes A1,A2,A3, exactly 5 cmd_read pulses, error=0.
REQ-039 xfade_log2=2, pipe0=+1000, pipe1=-1000, pipe_ready=0b0011, send 0x91 -> out 1000,500,0,-500, then -1000, active=1.
REQ-040 Send 0x80 while active=0, L=2 -> error=1, 4 bytes popped, fwd_ready never asserted.
REQ-041 Send 0x97 with n_pipelines=4 -> error=1, active unchanged; 0x90 with active=0 -> no-op, error=0.
REQ-042 Assert reset during XFADE at c=1 -> next cycle active=0, out_sample=0, swapping=0.
REQ-043 SWAP_XFADE_EN undefined, swap 0->1 -> output steps +1000 to -1000 at first sample after pipe_ready[1].
